// File: rtl/sdm_decimator_acc.sv
// ---------------------------------------------------------------------------
// sdm_decimator_acc
//
// Sinc1 (boxcar) decimator for a 1-bit sigma-delta bitstream. It sits
// directly downstream of a counter_modn and uses the counter's running value
// to frame N-sample windows. The block counts the ones in each window and
// presents one result word per window on a valid/ready output port.
//
// Parameters
//   N           window length in enabled i_clk cycles (matches counter_modn N)
//   CNT_WIDTH   width of i_cnt (matches counter_modn WIDTH)
//   OUT_WIDTH   width of o_data, at least clog2(N+1)+SIGNED_OUT
//   SIGNED_OUT  0: ones count 0..N ; 1: two's complement 2*ones-N, -N..+N
//
// Ports
//   i_clk      in   system clock, rising edge
//   i_rst      in   asynchronous active-low reset
//   i_en       in   sample enable, shared with counter_modn.i_en
//   i_bit      in   bitstream sample
//   i_cnt      in   counter_modn.o_data; the window closes on value N-1
//   o_data     out  result of the most recent window
//   o_valid    out  o_data holds a result not yet consumed
//   i_ready    in   consumer ready
//   o_ovr      out  sticky overrun flag: a window result was dropped
//   i_clr_ovr  in   synchronous clear of o_ovr
//
// Handshake: a word transfers on every rising edge where o_valid=1 and
// i_ready=1. While o_valid=1 and i_ready=0, o_data and o_valid hold steady.
// o_valid never depends on i_ready within a cycle; a new result may be
// loaded on the same edge that the previous word is accepted.
// ---------------------------------------------------------------------------
module sdm_decimator_acc #(
  parameter int N          = 21,
  parameter int CNT_WIDTH  = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int SIGNED_OUT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_bit,
  input  logic [CNT_WIDTH-1:0] i_cnt,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_ovr,
  input  logic                 i_clr_ovr
);

  localparam int ACC_W = $clog2(N + 1);

  // SYNC: waiting for the first window boundary so that the first result
  // covers a complete window. RUN: accumulating and emitting.
  typedef enum logic {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [ACC_W-1:0]      r_acc;
  logic [OUT_WIDTH-1:0]  r_data;
  logic                  r_valid;
  logic                  r_ovr;

  state_t                w_state_nxt;
  logic [ACC_W-1:0]      w_acc_nxt;
  logic [OUT_WIDTH-1:0]  w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_ovr_nxt;

  logic                  w_tc;
  logic                  w_slot_free;
  logic [ACC_W-1:0]      w_res;
  logic [OUT_WIDTH-1:0]  w_res_ext;
  logic [OUT_WIDTH-1:0]  w_out;

  // Window boundary: only an enabled cycle with the counter on its last
  // value. Out-of-range counter values can never match.
  assign w_tc = i_en && (i_cnt == CNT_WIDTH'(N - 1));

  // The output register can take a new word if it is empty or if its
  // current word is being accepted on this same edge.
  assign w_slot_free = !r_valid || i_ready;

  // The sample on the terminal cycle still belongs to the closing window.
  assign w_res     = r_acc + ACC_W'(i_bit);
  assign w_res_ext = OUT_WIDTH'(w_res);

  // Signed form 2*ones-N. Computed modulo 2^OUT_WIDTH, which gives the
  // correct sign-extended two's complement value when OUT_WIDTH is wide
  // enough to hold -N..+N.
  always_comb begin
    w_out = w_res_ext;
    if (SIGNED_OUT != 0) begin
      w_out = (w_res_ext << 1) - OUT_WIDTH'(N);
    end
  end

  // State register and all datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_SYNC;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_data_nxt  = r_data;
    // An accepted word empties the slot unless a new result refills it below.
    w_valid_nxt = r_valid && !i_ready;
    // Clear request applies unless a drop below sets the flag again.
    w_ovr_nxt   = r_ovr && !i_clr_ovr;

    case (r_state)
      S_SYNC: begin
        // Partial window before the first boundary is discarded.
        if (w_tc) begin
          w_acc_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_tc) begin
          w_acc_nxt = '0;
          if (w_slot_free) begin
            w_data_nxt  = w_out;
            w_valid_nxt = 1'b1;
          end else begin
            // Consumer is stalled on an older word: keep it, lose this one.
            w_ovr_nxt = 1'b1;
          end
        end else if (i_en) begin
          w_acc_nxt = r_acc + ACC_W'(i_bit);
        end
      end
      default: begin
        w_state_nxt = S_SYNC;
      end
    endcase
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovr   = r_ovr;

endmodule

// File: tb/tb_sdm_decimator_acc.sv
// ---------------------------------------------------------------------------
// tb_sdm_decimator_acc
//
// Drives an unsigned and a signed instance of sdm_decimator_acc from one
// shared stimulus stream and a behavioural mod-N counter. A reference model
// tracks the samples of each window, the output slot and the overrun flag;
// accepted words are checked against an expected queue.
// ---------------------------------------------------------------------------
module tb_sdm_decimator_acc;

  localparam int N  = 21;
  localparam int CW = 8;
  localparam int OW = 8;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_en      = 1'b0;
  logic          i_bit     = 1'b0;
  logic [CW-1:0] i_cnt     = '0;
  logic          i_ready   = 1'b0;
  logic          i_clr_ovr = 1'b0;

  logic [OW-1:0] o_data_u, o_data_s;
  logic          o_valid_u, o_valid_s;
  logic          o_ovr_u, o_ovr_s;

  sdm_decimator_acc #(.N(N), .CNT_WIDTH(CW), .OUT_WIDTH(OW), .SIGNED_OUT(0)) dut_u (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_bit(i_bit), .i_cnt(i_cnt),
    .o_data(o_data_u), .o_valid(o_valid_u), .i_ready(i_ready),
    .o_ovr(o_ovr_u), .i_clr_ovr(i_clr_ovr)
  );

  sdm_decimator_acc #(.N(N), .CNT_WIDTH(CW), .OUT_WIDTH(OW), .SIGNED_OUT(1)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_bit(i_bit), .i_cnt(i_cnt),
    .o_data(o_data_s), .o_valid(o_valid_s), .i_ready(i_ready),
    .o_ovr(o_ovr_s), .i_clr_ovr(i_clr_ovr)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [OW-1:0] exp_q_u[$];
  logic [OW-1:0] exp_q_s[$];

  int            cnt_m    = 0;    // feeding counter value
  bit            m_synced = 1'b0; // a window boundary has been seen
  bit            win_q[$];        // samples of the window in progress
  logic          m_valid  = 1'b0;
  logic          m_ovr    = 1'b0;
  logic [OW-1:0] m_data_u = '0;
  logic [OW-1:0] m_data_s = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    cnt_m    = 0;
    m_synced = 1'b0;
    win_q.delete();
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_data_u = '0;
    m_data_s = '0;
    exp_q_u.delete();
    exp_q_s.delete();
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid_u"}, 32'(o_valid_u), 32'(m_valid));
    check_eq({tag, "_valid_s"}, 32'(o_valid_s), 32'(m_valid));
    check_eq({tag, "_data_u"},  32'(o_data_u),  32'(m_data_u));
    check_eq({tag, "_data_s"},  32'(o_data_s),  32'(m_data_s));
    check_eq({tag, "_ovr_u"},   32'(o_ovr_u),   32'(m_ovr));
    check_eq({tag, "_ovr_s"},   32'(o_ovr_s),   32'(m_ovr));
  endtask

  // ---------------- driver ----------------
  // One clock cycle. Called at posedge+1; drives inputs, scores any
  // transfer happening on the coming edge, advances the model, then
  // samples the DUT 1 time unit after the edge.
  task automatic step(input logic e, input logic b, input logic r, input logic c,
                      input int cnt_force = -1);
    bit   tc;
    bit   produce;
    int   ones;
    i_en      = e;
    i_bit     = b;
    i_ready   = r;
    i_clr_ovr = c;
    i_cnt     = (cnt_force >= 0) ? CW'(cnt_force) : CW'(cnt_m);

    // Scoreboard: a word transferring on this edge must be the oldest expected one.
    if (o_valid_u && r) begin
      check_eq("sb_u_avail", 32'(exp_q_u.size() != 0), 32'd1);
      if (exp_q_u.size() != 0) check_eq("sb_u_word", 32'(o_data_u), 32'(exp_q_u.pop_front()));
    end
    if (o_valid_s && r) begin
      check_eq("sb_s_avail", 32'(exp_q_s.size() != 0), 32'd1);
      if (exp_q_s.size() != 0) check_eq("sb_s_word", 32'(o_data_s), 32'(exp_q_s.pop_front()));
    end

    // Window bookkeeping.
    tc      = e && (int'(i_cnt) == N - 1);
    produce = 1'b0;
    ones    = 0;
    if (e) begin
      if (tc) begin
        if (m_synced) begin
          foreach (win_q[k]) ones += int'(win_q[k]);
          ones += int'(b);
          produce = 1'b1;
        end
        m_synced = 1'b1;
        win_q.delete();
      end else if (m_synced) begin
        win_q.push_back(b);
      end
    end

    // Output slot and overrun flag.
    if (produce) begin
      if (!m_valid || r) begin
        m_valid  = 1'b1;
        m_data_u = OW'(ones);
        m_data_s = OW'(2 * ones - N);
        exp_q_u.push_back(m_data_u);
        exp_q_s.push_back(m_data_s);
        if (c) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (m_valid && r) m_valid = 1'b0;
      if (c) m_ovr = 1'b0;
    end

    // Feeding mod-N counter (frozen while its value is being overridden).
    if (e && cnt_force < 0) cnt_m = (cnt_m == N - 1) ? 0 : cnt_m + 1;

    @(posedge i_clk);
    #1;
    check_outputs("cyc");
  endtask

  // Reset pulse placed mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic async_reset();
    #3;
    i_rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_async_valid_u", 32'(o_valid_u), 32'd0);
    check_eq("rst_async_valid_s", 32'(o_valid_s), 32'd0);
    check_eq("rst_async_data_u",  32'(o_data_u),  32'd0);
    check_eq("rst_async_data_s",  32'(o_data_s),  32'd0);
    check_eq("rst_async_ovr_u",   32'(o_ovr_u),   32'd0);
    @(posedge i_clk);
    #1;
    i_cnt = '0;
    i_rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    logic sb;
    logic saw_drop;

    // Power-on reset.
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs("reset");
    i_rst = 1'b1;

    // 1: all ones, always ready -> first window discarded, then 21 per window.
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("t1_words_emitted", 32'(exp_q_u.size()), 32'd0);

    // 2: alternating bits -> 10/11 unsigned, -1/+1 signed.
    sb = 1'b1;
    for (int i = 0; i < 4 * N; i++) begin
      step(1'b1, sb, 1'b1, 1'b0);
      sb = ~sb;
    end

    // 3: stall across two window boundaries -> hold first, drop second.
    for (int i = 0; i < 2 * N + 2; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check_eq("t3_ovr_set_u", 32'(o_ovr_u), 32'd1);
    check_eq("t3_held_valid", 32'(o_valid_u), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t3_ovr_clr_u", 32'(o_ovr_u), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

    // 4: accept on the exact boundary cycle while a word is pending.
    for (k = 0; k < 3 * N && m_valid; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (k = 0; k < 3 * N && !m_valid; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (k = 0; k < 3 * N && cnt_m != N - 1; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check_eq("t4_aligned", 32'(m_valid && cnt_m == N - 1), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("t4_valid_kept", 32'(o_valid_u), 32'd1);
    check_eq("t4_no_ovr", 32'(o_ovr_u), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

    // 5: enable gap mid-window, plus out-of-range counter values.
    for (k = 0; k < 3 * N && cnt_m != 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2 * N + 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (k = 0; k < 3 * N && cnt_m != 8; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, $urandom_range(N, 255));
    step(1'b1, 1'b0, 1'b1, 1'b0, N);
    for (int i = 0; i < 2 * N; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

    // 6: reset while a word is pending, then resynchronise.
    for (k = 0; k < 3 * N && !m_valid; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t6_pending", 32'(o_valid_u), 32'd1);
    async_reset();
    for (int i = 0; i < 3 * N; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);

    // Random traffic: gaps, back-pressure, overrun clears.
    saw_drop = 1'b0;
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      if (m_ovr) saw_drop = 1'b1;
    end
    // Drain.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("drain_q_u", 32'(exp_q_u.size()), 32'd0);
    check_eq("drain_q_s", 32'(exp_q_s.size()), 32'd0);
    if (saw_drop) $display("note: random phase exercised overrun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
